// File: rtl/mips_ctrl_pkg.sv
// Opcode map and sequencer state encoding shared by the multicycle control blocks.
package mips_ctrl_pkg;

   localparam logic [5:0] OP_ADD  = 6'd1;
   localparam logic [5:0] OP_SUB  = 6'd2;
   localparam logic [5:0] OP_ADDI = 6'd3;
   localparam logic [5:0] OP_LW   = 6'd4;
   localparam logic [5:0] OP_SW   = 6'd5;
   localparam logic [5:0] OP_AND  = 6'd6;
   localparam logic [5:0] OP_OR   = 6'd7;
   localparam logic [5:0] OP_NOR  = 6'd8;
   localparam logic [5:0] OP_BEQ  = 6'd9;
   localparam logic [5:0] OP_BNE  = 6'd10;
   localparam logic [5:0] OP_SLT  = 6'd11;
   localparam logic [5:0] OP_EOF  = 6'd12;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT,
      S_ERROR
   } state_t;

   // Anything outside the defined 1..12 range retires as a no-op.
   function automatic logic is_nop(input logic [5:0] op);
      return (op == 6'd0) || (op > OP_EOF);
   endfunction

endpackage

// File: rtl/seq_wait_watchdog.sv
// Memory-wait watchdog: counts not-ready cycles in FETCH/MEM, flags timeout combinationally.
// Latency: timeout rises in the TIMEOUT-th consecutive not-ready cycle; no backpressure.
module seq_wait_watchdog #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic wait_active,
   input  logic ready,
   output logic timeout
);

   localparam int W = $clog2(TIMEOUT + 1);

   logic [W-1:0] cnt;

   // Cleared outside a wait and on ready, so each FETCH/MEM visit starts from zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (!wait_active || ready)
         cnt <= '0;
      else if (!timeout)
         cnt <= cnt + 1'b1;
   end

   assign timeout = wait_active && !ready && (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/mips_multicycle_sequencer.sv
// Multicycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB with Mealy step strobes, halts on eof.
// Latency ALU 4, lw 5, sw 4, branch 3, NOP 2; stalls on imem/dmem ready; SEQ_WATCHDOG_EN adds wait timeout.
module mips_multicycle_sequencer
   import mips_ctrl_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [5:0]       opcode,
   input  logic             branch_taken,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   output logic             imem_req,
   output logic             ir_we,
   output logic             pc_we,
   output logic             pc_sel,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic             reg_we,
   output logic             wb_data_sel,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [CNT_W-1:0] instr_count
);

   state_t state, state_nxt;
   logic   timeout;

`ifdef SEQ_WATCHDOG_EN
   logic wait_active;
   logic wait_ready;

   assign wait_active = (state == S_FETCH) || (state == S_MEM);
   assign wait_ready  = (state == S_FETCH) ? imem_ready : dmem_ready;

   seq_wait_watchdog #(.TIMEOUT(MEM_TIMEOUT)) u_wait_watchdog (
      .clk         (clk),
      .reset       (reset),
      .wait_active (wait_active),
      .ready       (wait_ready),
      .timeout     (timeout)
   );

   assign error = (state == S_ERROR);
`else
   // Waits are unbounded here; the timeout term folds to a constant 0.
   assign timeout = (MEM_TIMEOUT < 0);
   assign error   = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      imem_req    = 1'b0;
      ir_we       = 1'b0;
      pc_we       = 1'b0;
      pc_sel      = 1'b0;
      dmem_req    = 1'b0;
      dmem_we     = 1'b0;
      reg_we      = 1'b0;
      wb_data_sel = 1'b0;
      done        = 1'b0;
      case (state)
         S_IDLE: begin
            if (start)
               state_nxt = S_FETCH;
         end
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               ir_we     = 1'b1;
               state_nxt = S_DECODE;
            end else if (timeout) begin
               state_nxt = S_ERROR;
            end
         end
         S_DECODE: begin
            if (opcode == OP_EOF) begin
               state_nxt = S_HALT;
            end else if (is_nop(opcode)) begin
               pc_we     = 1'b1;
               state_nxt = S_FETCH;
            end else begin
               state_nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            if (opcode == OP_BEQ || opcode == OP_BNE) begin
               pc_we     = 1'b1;
               pc_sel    = branch_taken;
               state_nxt = S_FETCH;
            end else if (opcode == OP_LW || opcode == OP_SW) begin
               state_nxt = S_MEM;
            end else begin
               state_nxt = S_WB;
            end
         end
         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = (opcode == OP_SW);
            if (dmem_ready) begin
               if (opcode == OP_SW) begin
                  pc_we     = 1'b1;
                  state_nxt = S_FETCH;
               end else begin
                  state_nxt = S_WB;
               end
            end else if (timeout) begin
               state_nxt = S_ERROR;
            end
         end
         S_WB: begin
            reg_we      = 1'b1;
            wb_data_sel = (opcode == OP_LW);
            pc_we       = 1'b1;
            state_nxt   = S_FETCH;
         end
         S_HALT: begin
            done = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign busy = state inside {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB};

   // Every pc_we pulse is a retirement; the counter sticks at all-ones.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         instr_count <= '0;
      else if (pc_we && (instr_count != {CNT_W{1'b1}}))
         instr_count <= instr_count + 1'b1;
   end

endmodule

// File: tb/tb_mips_multicycle_sequencer.sv
// Bench: two sequencer instances (default, and CNT_W=2/MEM_TIMEOUT=4) driven in lockstep against a per-instruction cycle model.
module tb_mips_multicycle_sequencer;
   import mips_ctrl_pkg::*;

   typedef logic [10:0] vec_t;
   localparam int IREQ = 10, IRWE = 9, PCWE = 8, PCSEL = 7, DREQ = 6, DWE = 5;
   localparam int RWE = 4, WBS = 3, BUSY = 2, DONE = 1, ERR = 0;

   logic       clk = 1'b0;
   logic       reset, start, branch_taken, imem_ready, dmem_ready;
   logic [5:0] opcode;

   logic a_imem_req, a_ir_we, a_pc_we, a_pc_sel, a_dmem_req, a_dmem_we;
   logic a_reg_we, a_wb_data_sel, a_busy, a_done, a_error;
   logic [15:0] a_cnt;
   logic b_imem_req, b_ir_we, b_pc_we, b_pc_sel, b_dmem_req, b_dmem_we;
   logic b_reg_we, b_wb_data_sel, b_busy, b_done, b_error;
   logic [1:0] b_cnt;

   vec_t obs_a, obs_b;
   assign obs_a = {a_imem_req, a_ir_we, a_pc_we, a_pc_sel, a_dmem_req, a_dmem_we,
                   a_reg_we, a_wb_data_sel, a_busy, a_done, a_error};
   assign obs_b = {b_imem_req, b_ir_we, b_pc_we, b_pc_sel, b_dmem_req, b_dmem_we,
                   b_reg_we, b_wb_data_sel, b_busy, b_done, b_error};

   mips_multicycle_sequencer dut_a (
      .clk(clk), .reset(reset), .start(start), .opcode(opcode), .branch_taken(branch_taken),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(a_imem_req), .ir_we(a_ir_we),
      .pc_we(a_pc_we), .pc_sel(a_pc_sel), .dmem_req(a_dmem_req), .dmem_we(a_dmem_we),
      .reg_we(a_reg_we), .wb_data_sel(a_wb_data_sel), .busy(a_busy), .done(a_done),
      .error(a_error), .instr_count(a_cnt)
   );

   mips_multicycle_sequencer #(.CNT_W(2), .MEM_TIMEOUT(4)) dut_b (
      .clk(clk), .reset(reset), .start(start), .opcode(opcode), .branch_taken(branch_taken),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(b_imem_req), .ir_we(b_ir_we),
      .pc_we(b_pc_we), .pc_sel(b_pc_sel), .dmem_req(b_dmem_req), .dmem_we(b_dmem_we),
      .reg_we(b_reg_we), .wb_data_sel(b_wb_data_sel), .busy(b_busy), .done(b_done),
      .error(b_error), .instr_count(b_cnt)
   );

   always #5 clk = ~clk;

   int   n_vec = 0;
   int   n_err = 0;
   int   model_cnt = 0;
   vec_t exp_q[$];
   vec_t exp2_q[$];
   int   ir_q[$];
   int   dr_q[$];
   bit   ret_q[$];

   function automatic vec_t bv(input int b);
      return vec_t'(1) << b;
   endfunction

   task automatic check_cycle(input vec_t e1, input vec_t e2, input string tag);
      logic [15:0] ea;
      logic [1:0]  eb;
      ea = 16'(model_cnt);
      eb = 2'((model_cnt > 3) ? 3 : model_cnt);
      n_vec++;
      assert (obs_a === e1) else begin
         n_err++; $error("FAIL %s outputs_a got %b expected %b", tag, obs_a, e1);
      end
      n_vec++;
      assert (obs_b === e2) else begin
         n_err++; $error("FAIL %s outputs_b got %b expected %b", tag, obs_b, e2);
      end
      n_vec++;
      assert (a_cnt === ea) else begin
         n_err++; $error("FAIL %s count_a got %0d expected %0d", tag, a_cnt, ea);
      end
      n_vec++;
      assert (b_cnt === eb) else begin
         n_err++; $error("FAIL %s count_b got %0d expected %0d", tag, b_cnt, eb);
      end
   endtask

   // ready encoding in the queues: 0/1 driven as-is, 2 = don't care (random)
   task automatic push(input vec_t v, input int ir, input int dr, input bit ret);
      exp_q.push_back(v);
      exp2_q.push_back(v);
      ir_q.push_back(ir);
      dr_q.push_back(dr);
      ret_q.push_back(ret);
   endtask

   // Builds the expected cycle-by-cycle profile of one instruction, then plays it.
   task automatic do_instr(input logic [5:0] op, input logic bt, input int wi, input int wd,
                           input int abort_at, input bit stall);
      vec_t mb;
      exp_q.delete(); exp2_q.delete(); ir_q.delete(); dr_q.delete(); ret_q.delete();
      for (int j = 0; j < wi; j++) push(bv(IREQ) | bv(BUSY), 0, 2, 0);
      push(bv(IREQ) | bv(IRWE) | bv(BUSY), 1, 2, 0);
      if (op == OP_EOF) begin
         push(bv(BUSY), 2, 2, 0);
      end else if (op == 6'd0 || op > 6'd12) begin
         push(bv(PCWE) | bv(BUSY), 2, 2, 1);
      end else begin
         push(bv(BUSY), 2, 2, 0);
         if (op == OP_BEQ || op == OP_BNE) begin
            push(bv(PCWE) | (bt ? bv(PCSEL) : '0) | bv(BUSY), 2, 2, 1);
         end else begin
            push(bv(BUSY), 2, 2, 0);
            if (op == OP_LW || op == OP_SW) begin
               mb = bv(DREQ) | bv(BUSY) | ((op == OP_SW) ? bv(DWE) : '0);
               for (int j = 0; j < wd; j++) begin
                  push(mb, 2, 0, 0);
`ifdef SEQ_WATCHDOG_EN
                  if (stall && j >= 4) exp2_q[exp2_q.size() - 1] = bv(ERR);
`endif
               end
               if (!stall) push(mb | ((op == OP_SW) ? bv(PCWE) : '0), 2, 1, op == OP_SW);
            end
            if (op != OP_SW && !stall)
               push(bv(RWE) | ((op == OP_LW) ? bv(WBS) : '0) | bv(PCWE) | bv(BUSY), 2, 2, 1);
         end
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         @(posedge clk); #1;
         opcode       = op;
         branch_taken = (op == OP_BEQ || op == OP_BNE) ? bt : 1'($urandom_range(0, 1));
         imem_ready   = (ir_q[i] == 2) ? 1'($urandom_range(0, 1)) : 1'(ir_q[i]);
         dmem_ready   = (dr_q[i] == 2) ? 1'($urandom_range(0, 1)) : 1'(dr_q[i]);
         start        = 1'($urandom_range(0, 1));
         if (i == abort_at) begin
            reset = 1'b1;
            start = 1'b0;
            model_cnt = 0;
            @(negedge clk);
            check_cycle('0, '0, "abort");
            @(posedge clk); #1;
            reset = 1'b0;
            return;
         end
         @(negedge clk);
         check_cycle(exp_q[i], exp2_q[i], $sformatf("op%0d_c%0d", op, i));
         if (ret_q[i]) model_cnt++;
      end
   endtask

   task automatic start_run();
      @(posedge clk); #1;
      start = 1'b1;
      @(negedge clk);
      check_cycle('0, '0, "idle");
   endtask

   task automatic halt_check(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         start = 1'($urandom_range(0, 1));
         @(negedge clk);
         check_cycle(bv(DONE), bv(DONE), "halt");
      end
   endtask

   task automatic reset_pulse();
      @(posedge clk); #1;
      reset = 1'b1;
      start = 1'b0;
      model_cnt = 0;
      @(negedge clk);
      check_cycle('0, '0, "reset");
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   initial begin
      logic [5:0] rop;
      reset = 1'b1; start = 1'b0; opcode = '0; branch_taken = 1'b0;
      imem_ready = 1'b0; dmem_ready = 1'b0;
      repeat (2) @(negedge clk);
      check_cycle('0, '0, "reset_state");
      @(posedge clk); #1;
      reset = 1'b0;

      // zero-wait program: add, lw, sw, taken beq, eof
      start_run();
      do_instr(OP_ADD, 1'b0, 0, 0, -1, 1'b0);
      do_instr(OP_LW,  1'b0, 0, 0, -1, 1'b0);
      do_instr(OP_SW,  1'b0, 0, 0, -1, 1'b0);
      do_instr(OP_BEQ, 1'b1, 0, 0, -1, 1'b0);
      do_instr(OP_EOF, 1'b0, 0, 0, -1, 1'b0);
      halt_check(5);

      // fetch stall, untaken bne, high-opcode NOP, addi run into saturation
      reset_pulse();
      start_run();
      do_instr(OP_ADD, 1'b0, 3, 0, -1, 1'b0);
      do_instr(OP_BNE, 1'b0, 0, 0, -1, 1'b0);
      do_instr(6'h3F,  1'b0, 0, 0, -1, 1'b0);
      for (int k = 0; k < 5; k++) do_instr(OP_ADDI, 1'b0, 0, 0, -1, 1'b0);

      for (int k = 0; k < 40; k++) begin
         rop = 6'($urandom_range(0, 63));
         if (rop == OP_EOF) rop = 6'd13;
         do_instr(rop, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), -1, 1'b0);
      end

      // reset lands in the second MEM wait cycle of a lw
      do_instr(OP_LW, 1'b0, 0, 3, 4, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      check_cycle('0, '0, "post_abort");

      // sw with dmem never ready
      start_run();
      do_instr(OP_SW, 1'b0, 0, 100, -1, 1'b1);
      reset_pulse();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout bench did not complete, %0d vectors applied", n_vec);
      $fatal(1, "bench time limit");
   end

endmodule
